// File: rtl/if_stage.sv
// Fetch stage: registers the pre-IF PC and its same-cycle SRAM word, offers it to ID,
// and blocks on ADEF faults until a redirect. Optional counters under IF_PERF_CNT_EN.
module if_stage #(
   parameter logic [31:0] NOP_INST   = 32'h03400000,
   parameter logic [5:0]  ECODE_ADEF = 6'h08
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pre_valid,
   input  logic [31:0] pre_pc,
   input  logic        pre_excp_adef,
   input  logic [31:0] inst_sram_rdata,
   input  logic        ds_allowin,
   input  logic        br_taken_cancel,
   input  logic        excp_flush,
   input  logic        ertn_flush,
   output logic        fs_allowin,
   output logic        fs_stall,
   output logic        fs_to_ds_valid,
   output logic [31:0] fs_pc,
   output logic [31:0] fs_inst,
   output logic        fs_excp,
   output logic [5:0]  fs_ecode
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] fs_cnt_fetch,
   output logic [31:0] fs_cnt_stall,
   output logic [31:0] fs_cnt_flush
`endif
);

   typedef enum logic [0:0] {
      RUN        = 1'b0,
      EXCP_BLOCK = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_nextState;

   logic        r_fsValid;
   logic [31:0] r_fsPc;
   logic [31:0] r_fsInst;
   logic        r_fsExcp;
   logic [5:0]  r_fsEcode;

   logic        w_flush;
   logic        w_allowin;
   logic        w_capture;
   logic        w_drain;

   assign w_flush   = br_taken_cancel | excp_flush | ertn_flush;
   assign w_capture = pre_valid & w_allowin & ~w_flush;
   assign w_drain   = r_fsValid & ds_allowin & ~w_capture;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= RUN;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Only a redirect releases the ADEF block; the faulting instruction draining does not.
   always_comb begin
      w_nextState = r_state;
      if (w_flush) begin
         w_nextState = RUN;
      end else if (w_capture && pre_excp_adef) begin
         w_nextState = EXCP_BLOCK;
      end
   end

   always_comb begin
      w_allowin = 1'b0;
      if (r_state == RUN) begin
         w_allowin = ~r_fsValid | ds_allowin;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fsValid <= 1'b0;
         r_fsPc    <= 32'd0;
         r_fsInst  <= 32'd0;
         r_fsExcp  <= 1'b0;
         r_fsEcode <= 6'd0;
      end else if (w_flush) begin
         r_fsValid <= 1'b0;
      end else if (w_capture) begin
         r_fsValid <= 1'b1;
         r_fsPc    <= pre_pc;
         if (pre_excp_adef) begin
            r_fsInst  <= NOP_INST;
            r_fsExcp  <= 1'b1;
            r_fsEcode <= ECODE_ADEF;
         end else begin
            r_fsInst  <= inst_sram_rdata;
            r_fsExcp  <= 1'b0;
            r_fsEcode <= 6'd0;
         end
      end else if (w_drain) begin
         r_fsValid <= 1'b0;
      end
   end

   assign fs_allowin     = w_allowin;
   assign fs_stall       = ~w_allowin;
   assign fs_to_ds_valid = r_fsValid & ~w_flush;
   assign fs_pc          = r_fsPc;
   assign fs_inst        = r_fsInst;
   assign fs_excp        = r_fsExcp;
   assign fs_ecode       = r_fsEcode;

`ifdef IF_PERF_CNT_EN
   logic [31:0] r_cntFetch;
   logic [31:0] r_cntStall;
   logic [31:0] r_cntFlush;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cntFetch <= 32'd0;
         r_cntStall <= 32'd0;
         r_cntFlush <= 32'd0;
      end else begin
         if (w_capture) begin
            r_cntFetch <= r_cntFetch + 32'd1;
         end
         if (pre_valid && !w_allowin && !w_flush) begin
            r_cntStall <= r_cntStall + 32'd1;
         end
         if (w_flush) begin
            r_cntFlush <= r_cntFlush + 32'd1;
         end
      end
   end

   assign fs_cnt_fetch = r_cntFetch;
   assign fs_cnt_stall = r_cntStall;
   assign fs_cnt_flush = r_cntFlush;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed fetch sequence; expected ID transfers are queued and
// checked by an independent monitor, plus direct checks of handshake outputs.
module tb_if_stage;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        excp;
      logic [5:0]  ecode;
   } xfer_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        pre_valid;
   logic [31:0] pre_pc;
   logic        pre_excp_adef;
   logic [31:0] inst_sram_rdata;
   logic        ds_allowin;
   logic        br_taken_cancel;
   logic        excp_flush;
   logic        ertn_flush;
   logic        fs_allowin;
   logic        fs_stall;
   logic        fs_to_ds_valid;
   logic [31:0] fs_pc;
   logic [31:0] fs_inst;
   logic        fs_excp;
   logic [5:0]  fs_ecode;
`ifdef IF_PERF_CNT_EN
   logic [31:0] fs_cnt_fetch;
   logic [31:0] fs_cnt_stall;
   logic [31:0] fs_cnt_flush;
`endif

   int    compared   = 0;
   int    mismatched = 0;
   xfer_t expQ[$];
   logic  done = 1'b0;

   always #5 clk = ~clk;

   if_stage dut (
      .clk             (clk),
      .reset           (reset),
      .pre_valid       (pre_valid),
      .pre_pc          (pre_pc),
      .pre_excp_adef   (pre_excp_adef),
      .inst_sram_rdata (inst_sram_rdata),
      .ds_allowin      (ds_allowin),
      .br_taken_cancel (br_taken_cancel),
      .excp_flush      (excp_flush),
      .ertn_flush      (ertn_flush),
      .fs_allowin      (fs_allowin),
      .fs_stall        (fs_stall),
      .fs_to_ds_valid  (fs_to_ds_valid),
      .fs_pc           (fs_pc),
      .fs_inst         (fs_inst),
      .fs_excp         (fs_excp),
      .fs_ecode        (fs_ecode)
`ifdef IF_PERF_CNT_EN
      ,
      .fs_cnt_fetch    (fs_cnt_fetch),
      .fs_cnt_stall    (fs_cnt_stall),
      .fs_cnt_flush    (fs_cnt_flush)
`endif
   );

   // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
   task automatic applyStimulus(input logic rst, input logic pv, input logic [31:0] pc,
                                input logic adef, input logic [31:0] rdata,
                                input logic dsa, input logic br, input logic ex,
                                input logic er);
      @(posedge clk);
      #1;
      reset           = rst;
      pre_valid       = pv;
      pre_pc          = pc;
      pre_excp_adef   = adef;
      inst_sram_rdata = rdata;
      ds_allowin      = dsa;
      br_taken_cancel = br;
      excp_flush      = ex;
      ertn_flush      = er;
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
      end
   endtask

   function automatic xfer_t mk(input logic [31:0] pc, input logic [31:0] inst,
                                input logic excp, input logic [5:0] ecode);
      xfer_t t;
      t.pc    = pc;
      t.inst  = inst;
      t.excp  = excp;
      t.ecode = ecode;
      return t;
   endfunction

   // Monitor: every accepted transfer to ID must match the next queued expectation.
   always @(negedge clk) begin
      if (!done && fs_to_ds_valid === 1'b1 && ds_allowin === 1'b1) begin
         compared++;
         if (expQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL xfer_unexpected: got pc 0x%08h, want no transfer", fs_pc);
         end else begin
            xfer_t e;
            e = expQ.pop_front();
            if (fs_pc !== e.pc || fs_inst !== e.inst || fs_excp !== e.excp ||
                fs_ecode !== e.ecode) begin
               mismatched++;
               $display("[TB] FAIL xfer: got pc 0x%08h inst 0x%08h excp %0b ecode 0x%02h, want pc 0x%08h inst 0x%08h excp %0b ecode 0x%02h",
                        fs_pc, fs_inst, fs_excp, fs_ecode, e.pc, e.inst, e.excp, e.ecode);
            end
         end
      end
   end

   initial begin
      #20000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1; pre_valid = 1'b0; pre_pc = 32'd0; pre_excp_adef = 1'b0;
      inst_sram_rdata = 32'd0; ds_allowin = 1'b0; br_taken_cancel = 1'b0;
      excp_flush = 1'b0; ertn_flush = 1'b0;

      applyStimulus(1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
      applyStimulus(1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
      checkOutput("rst_to_ds_valid", 32'(fs_to_ds_valid), 32'd0);
      checkOutput("rst_allowin", 32'(fs_allowin), 32'd1);
      checkOutput("rst_pc", fs_pc, 32'd0);
      checkOutput("rst_inst", fs_inst, 32'd0);

      // Streaming at full throughput
      applyStimulus(0, 1, 32'h1c000000, 0, 32'h02800421, 1, 0, 0, 0);
      expQ.push_back(mk(32'h1c000000, 32'h02800421, 1'b0, 6'h00));
      checkOutput("s0_to_ds_valid", 32'(fs_to_ds_valid), 32'd0);
      checkOutput("s0_allowin", 32'(fs_allowin), 32'd1);
      applyStimulus(0, 1, 32'h1c000004, 0, 32'h02800842, 1, 0, 0, 0);
      expQ.push_back(mk(32'h1c000004, 32'h02800842, 1'b0, 6'h00));
      checkOutput("s1_to_ds_valid", 32'(fs_to_ds_valid), 32'd1);
      checkOutput("s1_pc", fs_pc, 32'h1c000000);
      applyStimulus(0, 1, 32'h1c000008, 0, 32'h02800c63, 1, 0, 0, 0);
      expQ.push_back(mk(32'h1c000008, 32'h02800c63, 1'b0, 6'h00));
      checkOutput("s2_pc", fs_pc, 32'h1c000004);
      checkOutput("s2_allowin", 32'(fs_allowin), 32'd1);

      // Back-pressure for 3 cycles
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, 32'h1c00000c, 0, 32'h02801084, 0, 0, 0, 0);
         checkOutput("bp_stall", 32'(fs_stall), 32'd1);
         checkOutput("bp_pc", fs_pc, 32'h1c000008);
         checkOutput("bp_inst", fs_inst, 32'h02800c63);
      end
      applyStimulus(0, 1, 32'h1c00000c, 0, 32'h02801084, 1, 0, 0, 0);
      expQ.push_back(mk(32'h1c00000c, 32'h02801084, 1'b0, 6'h00));
      checkOutput("bp_release_stall", 32'(fs_stall), 32'd0);
      applyStimulus(0, 1, 32'h1c000010, 0, 32'h02801485, 1, 0, 0, 0);
      checkOutput("bp_next_pc", fs_pc, 32'h1c00000c);

      // Branch kill: 0x1c000010 held, 0x1c000014 offered
      applyStimulus(0, 1, 32'h1c000014, 0, 32'h02801886, 1, 1, 0, 0);
      checkOutput("br_to_ds_valid", 32'(fs_to_ds_valid), 32'd0);
      checkOutput("br_held_pc", fs_pc, 32'h1c000010);
      applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 0);
      checkOutput("br_after_valid", 32'(fs_to_ds_valid), 32'd0);
      checkOutput("br_after_allowin", 32'(fs_allowin), 32'd1);

      // ADEF fetch blocks further fetches until excp_flush
      applyStimulus(0, 1, 32'h1c000002, 1, 32'hdeadbeef, 0, 0, 0, 0);
      expQ.push_back(mk(32'h1c000002, 32'h03400000, 1'b1, 6'h08));
      checkOutput("adef_allowin_pre", 32'(fs_allowin), 32'd1);
      applyStimulus(0, 1, 32'h1c000008, 0, 32'h02800c63, 0, 0, 0, 0);
      checkOutput("adef_inst", fs_inst, 32'h03400000);
      checkOutput("adef_excp", 32'(fs_excp), 32'd1);
      checkOutput("adef_ecode", 32'(fs_ecode), 32'h08);
      checkOutput("adef_allowin_hold", 32'(fs_allowin), 32'd0);
      applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 0);
      checkOutput("adef_allowin_xfer", 32'(fs_allowin), 32'd0);
      applyStimulus(0, 1, 32'h1c000008, 0, 32'h02800c63, 1, 0, 0, 0);
      checkOutput("adef_allowin_drained", 32'(fs_allowin), 32'd0);
      checkOutput("adef_drained_valid", 32'(fs_to_ds_valid), 32'd0);
      applyStimulus(0, 1, 32'h1c000008, 0, 32'h02800c63, 1, 0, 1, 0);
      checkOutput("adef_flush_allowin", 32'(fs_allowin), 32'd0);
      applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 0);
      checkOutput("adef_released_allowin", 32'(fs_allowin), 32'd1);

      // ertn flush while stalled
      applyStimulus(0, 1, 32'h1c000020, 0, 32'h02800001, 0, 0, 0, 0);
      checkOutput("fs_cap_allowin", 32'(fs_allowin), 32'd1);
      applyStimulus(0, 1, 32'h1c000024, 0, 32'h02800002, 0, 0, 0, 1);
      checkOutput("fs_flush_to_ds", 32'(fs_to_ds_valid), 32'd0);
      checkOutput("fs_flush_stall", 32'(fs_stall), 32'd1);
      applyStimulus(0, 1, 32'h1c000024, 0, 32'h02800002, 0, 0, 0, 0);
      expQ.push_back(mk(32'h1c000024, 32'h02800002, 1'b0, 6'h00));
      checkOutput("fs_resume_allowin", 32'(fs_allowin), 32'd1);
      checkOutput("fs_resume_to_ds", 32'(fs_to_ds_valid), 32'd0);
      applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 0);
      checkOutput("fs_resume_pc", fs_pc, 32'h1c000024);

      // Reset while blocked on ADEF
      applyStimulus(0, 1, 32'h1c000032, 1, 32'h12345678, 0, 0, 0, 0);
      applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
      checkOutput("blk_allowin", 32'(fs_allowin), 32'd0);
`ifdef IF_PERF_CNT_EN
      checkOutput("cnt_fetch", fs_cnt_fetch, 32'd9);
      checkOutput("cnt_stall", fs_cnt_stall, 32'd5);
      checkOutput("cnt_flush", fs_cnt_flush, 32'd3);
`endif
      applyStimulus(1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
      applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
      checkOutput("rst2_to_ds_valid", 32'(fs_to_ds_valid), 32'd0);
      checkOutput("rst2_allowin", 32'(fs_allowin), 32'd1);
      checkOutput("rst2_pc", fs_pc, 32'd0);
      checkOutput("rst2_inst", fs_inst, 32'd0);
      checkOutput("rst2_excp", 32'(fs_excp), 32'd0);
      checkOutput("rst2_ecode", 32'(fs_ecode), 32'd0);
`ifdef IF_PERF_CNT_EN
      checkOutput("rst2_cnt_fetch", fs_cnt_fetch, 32'd0);
      checkOutput("rst2_cnt_stall", fs_cnt_stall, 32'd0);
      checkOutput("rst2_cnt_flush", fs_cnt_flush, 32'd0);
`endif

      applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 0);
      done = 1'b1;
      checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
